idft_frame_sched: RTL and testbench

- Frame-level sequencer for the 32-point IDFT core (4 x 16-bit lanes per 64-bit word).
- Accepts one 32-word input frame over a valid/ready stream and buffers it.
- Pulses the core's start strobe, then feeds the core one word per cycle.
- Captures the 32 result words on the core's output strobe and returns them over a valid/ready stream.
- Sits between the bus-side register interface (or a DMA) and the core, so software no longer steps words through registers.

---
 rtl/idft_frame_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_idft_frame_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idft_frame_sched.sv
`timescale 1ns/1ps
// idft_frame_sched: buffers one frame, streams it into the 32-point IDFT core,
// captures the core results on its output strobe and drains them downstream.
module idft_frame_sched #(
  parameter int WORDS   = 32,
  parameter int DW      = 64,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          abort_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  output logic          out_last_o,
  input  logic          out_ready_i,
  output logic          core_next_o,
  output logic [DW-1:0] core_x_o,
  input  logic          core_next_out_i,
  input  logic [DW-1:0] core_y_i,
  output logic          busy_o,
  output logic          err_timeout_o,
  output logic [CW-1:0] frame_cnt_o
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_FEED, S_WAIT_OUT, S_CAPTURE, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] feed_idx_q, feed_idx_d;
  logic [AW-1:0] cap_idx_q, cap_idx_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          cap_armed_q, cap_armed_d;
  logic          cap_done_q, cap_done_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          nxt_prev_q;
  logic          in_ready_q, in_ready_d;
  logic          core_next_q, core_next_d;
  logic [DW-1:0] core_x_q, core_x_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic          edge_ok, in_hs, out_hs, in_wr_en, out_wr_en;

  logic [DW-1:0] in_buf  [WORDS];
  logic [DW-1:0] out_buf [WORDS];

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    feed_idx_d  = feed_idx_q;
    cap_idx_d   = cap_idx_q;
    cap_armed_d = cap_armed_q;
    cap_done_d  = cap_done_q;
    rd_idx_d    = rd_idx_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    in_wr_en    = 1'b0;
    out_wr_en   = 1'b0;

    edge_ok = core_next_out_i & ~nxt_prev_q & ~cap_armed_q & ~cap_done_q
            & ((state_q == S_FEED) | (state_q == S_WAIT_OUT));
    in_hs   = in_valid_i & in_ready_q;
    out_hs  = out_valid_q & out_ready_i;

    // Capture runs alongside FEED, independent of the main state.
    if (cap_armed_q) begin
      out_wr_en = 1'b1;
      cap_idx_d = cap_idx_q + AW'(1);
      if (cap_idx_q == LAST) begin
        cap_armed_d = 1'b0;
        cap_done_d  = 1'b1;
      end
    end
    if (edge_ok) begin
      cap_armed_d = 1'b1;
      cap_idx_d   = '0;
    end

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_hs) begin
          in_wr_en = 1'b1;
          if (wr_idx_q == LAST) begin
            wr_idx_d = '0;
            state_d  = S_START;
          end else begin
            wr_idx_d = wr_idx_q + AW'(1);
            state_d  = S_LOAD;
          end
        end
      end
      S_START: begin
        tmo_d       = TW'(1);
        feed_idx_d  = '0;
        cap_idx_d   = '0;
        cap_armed_d = 1'b0;
        cap_done_d  = 1'b0;
        state_d     = S_FEED;
      end
      S_FEED: begin
        feed_idx_d = feed_idx_q + AW'(1);
        if (feed_idx_q == LAST) begin
          if (cap_done_d)       state_d = S_DRAIN;
          else if (cap_armed_d) state_d = S_CAPTURE;
          else                  state_d = S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: if (edge_ok) state_d = S_CAPTURE;
      S_CAPTURE:  if (cap_done_d) state_d = S_DRAIN;
      S_DRAIN: begin
        if (out_hs) begin
          if (rd_idx_q == LAST) begin
            rd_idx_d    = '0;
            cap_done_d  = 1'b0;
            frame_cnt_d = frame_cnt_q + CW'(1);
            state_d     = S_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tmo_q holds the number of cycles elapsed since the start pulse.
    if (((state_q == S_FEED) || (state_q == S_WAIT_OUT)) && !cap_armed_q && !cap_done_q && !edge_ok) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_d == TW'(TIMEOUT)) begin
        err_d      = 1'b1;
        feed_idx_d = '0;
        state_d    = S_IDLE;
      end
    end

    if (abort_i) begin
      state_d     = S_IDLE;
      wr_idx_d    = '0;
      feed_idx_d  = '0;
      cap_idx_d   = '0;
      rd_idx_d    = '0;
      cap_armed_d = 1'b0;
      cap_done_d  = 1'b0;
      tmo_d       = '0;
      err_d       = 1'b0;
      in_wr_en    = 1'b0;
      out_wr_en   = 1'b0;
    end

    in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
    core_next_d = (state_d == S_START);
    core_x_d    = (state_d == S_FEED) ? in_buf[feed_idx_d] : '0;
    out_valid_d = (state_d == S_DRAIN);
    out_data_d  = (state_d == S_DRAIN) ? out_buf[rd_idx_d] : '0;
    out_last_d  = (state_d == S_DRAIN) && (rd_idx_d == LAST);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      wr_idx_q    <= '0;
      feed_idx_q  <= '0;
      cap_idx_q   <= '0;
      rd_idx_q    <= '0;
      cap_armed_q <= 1'b0;
      cap_done_q  <= 1'b0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      nxt_prev_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      core_next_q <= 1'b0;
      core_x_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      feed_idx_q  <= feed_idx_d;
      cap_idx_q   <= cap_idx_d;
      rd_idx_q    <= rd_idx_d;
      cap_armed_q <= cap_armed_d;
      cap_done_q  <= cap_done_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      nxt_prev_q  <= core_next_out_i;
      in_ready_q  <= in_ready_d;
      core_next_q <= core_next_d;
      core_x_q    <= core_x_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Frame storage carries no reset; contents are always rewritten before use.
  always_ff @(posedge wb_clk_i) begin
    if (in_wr_en)  in_buf[wr_idx_q]   <= in_data_i;
    if (out_wr_en) out_buf[cap_idx_q] <= core_y_i;
  end

  assign in_ready_o    = in_ready_q;
  assign core_next_o   = core_next_q;
  assign core_x_o      = core_x_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_last_o    = out_last_q;
  assign busy_o        = busy_q;
  assign err_timeout_o = err_q;
  assign frame_cnt_o   = frame_cnt_q;
endmodule

// File: tb/tb_idft_frame_sched.sv
`timescale 1ns/1ps
// Directed bench for idft_frame_sched with a cycle-accurate behavioural core model.
module tb_idft_frame_sched;
  localparam int WORDS = 32;
  localparam int DW = 64;
  localparam int TIMEOUT = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_last_o;
  logic          out_ready_i = 1'b0;
  logic          core_next_o;
  logic [DW-1:0] core_x_o;
  logic          core_next_out_i;
  logic [DW-1:0] core_y_i;
  logic          busy_o;
  logic          err_timeout_o;
  logic [CW-1:0] frame_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  // core model state
  int            tcnt = -1;
  int            core_lat = 40;
  int            next_high = 0;
  int            xnz = 0;
  logic [DW-1:0] xcap [WORDS];

  idft_frame_sched #(.WORDS(WORDS), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .abort_i(abort_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .core_next_o(core_next_o), .core_x_o(core_x_o),
    .core_next_out_i(core_next_out_i), .core_y_i(core_y_i), .busy_o(busy_o),
    .err_timeout_o(err_timeout_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  // Core model: tcnt is the cycle index relative to the start pulse (cycle T).
  initial begin
    core_next_out_i = 1'b0;
    core_y_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (core_next_o) begin
        tcnt = 0;
        next_high++;
      end else if (tcnt >= 0) begin
        tcnt++;
      end
      if (tcnt >= 1 && tcnt <= WORDS) xcap[tcnt-1] = core_x_o;
      else if (core_x_o !== '0) xnz++;
      core_next_out_i = (core_lat > 0) && (tcnt == core_lat);
      if (core_lat > 0 && tcnt > core_lat && tcnt <= core_lat + WORDS)
        core_y_i = ~xcap[tcnt - core_lat - 1];
      else
        core_y_i = 64'hDEAD_BEEF_DEAD_BEEF;
    end
  end

  task automatic load_frame(input logic [DW-1:0] base, input int gap_pct, input int nwords);
    int k = 0;
    int guard = 0;
    while (k < nwords && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid_i = 1'b0;
      end else begin
        in_valid_i = 1'b1;
        in_data_i = base + DW'(k);
        if (in_ready_o) k++;
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    tests_run++;
    if (k != nwords) begin
      tests_failed++;
      $display("FAIL load_frame: accepted %0d words, required %0d", k, nwords);
    end
  endtask

  task automatic drain_frame(input logic [DW-1:0] base, input int bp_pct, input int lat,
                             input logic [CW-1:0] exp_cnt, input string tag);
    int got = 0;
    int cyc = 0;
    int rdy_bad = 0;
    logic stalled = 1'b0;
    logic hs;
    logic [DW-1:0] prev = '0;
    logic [DW-1:0] exp;
    while (!out_valid_o && cyc < 300) begin
      if (in_ready_o !== 1'b0) rdy_bad++;
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (out_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s drain_start: out_valid never rose", tag);
      return;
    end
    tests_run++;
    if (tcnt != lat + 33) begin
      tests_failed++;
      $display("FAIL %s drain_entry: first out_valid at T+%0d, required T+%0d", tag, tcnt, lat + 33);
    end
    cyc = 0;
    while (got < WORDS && cyc < 2000) begin
      exp = ~(base + DW'(got));
      tests_run++;
      if (out_valid_o !== 1'b1 || out_data_o !== exp || out_last_o !== 1'(got == WORDS-1)) begin
        tests_failed++;
        $display("FAIL %s drain_word[%0d]: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 tag, got, out_valid_o, out_data_o, out_last_o, exp, (got == WORDS-1));
      end
      if (stalled) begin
        tests_run++;
        if (out_data_o !== prev) begin
          tests_failed++;
          $display("FAIL %s stall_stable: data=%h, required held %h", tag, out_data_o, prev);
        end
      end
      if (in_ready_o !== 1'b0) rdy_bad++;
      hs = (int'($urandom_range(99)) >= bp_pct);
      out_ready_i = hs;
      prev = out_data_o;
      stalled = !hs;
      if (hs) got++;
      @(negedge clk);
      cyc++;
    end
    out_ready_i = 1'b0;
    tests_run++;
    if (out_valid_o !== 1'b0 || frame_cnt_o !== exp_cnt) begin
      tests_failed++;
      $display("FAIL %s drain_end: out_valid=%b frame_cnt=%0d, required 0 and %0d",
               tag, out_valid_o, frame_cnt_o, exp_cnt);
    end
    tests_run++;
    if (rdy_bad != 0) begin
      tests_failed++;
      $display("FAIL %s in_ready_busy: in_ready high %0d times, required 0", tag, rdy_bad);
    end
  endtask

  task automatic test_reset;
    #3;
    tests_run++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || err_timeout_o !== 1'b0 ||
        frame_cnt_o !== '0 || core_next_o !== 1'b0 || core_x_o !== '0 || out_data_o !== '0 || out_last_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b err=%b cnt=%0d nxt=%b x=%h d=%h last=%b, required all 0",
               in_ready_o, out_valid_o, busy_o, err_timeout_o, frame_cnt_o, core_next_o, core_x_o, out_data_o, out_last_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0 || frame_cnt_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle: in_ready=%b busy=%b cnt=%0d, required 1 0 0", in_ready_o, busy_o, frame_cnt_o);
    end
  endtask

  task automatic test_basic;
    int nh0;
    logic [DW-1:0] base = '0;
    core_lat = 40;
    nh0 = next_high;
    load_frame(base, 0, WORDS);
    drain_frame(base, 0, 40, 16'd1, "basic");
    tests_run++;
    if (next_high - nh0 != 1) begin
      tests_failed++;
      $display("FAIL basic_next_pulse: %0d high cycles, required 1", next_high - nh0);
    end
    for (int k = 0; k < WORDS; k++) begin
      tests_run++;
      if (xcap[k] !== base + DW'(k)) begin
        tests_failed++;
        $display("FAIL basic_core_x[%0d]: got %h, required %h", k, xcap[k], base + DW'(k));
      end
    end
    tests_run++;
    if (xnz != 0) begin
      tests_failed++;
      $display("FAIL core_x_idle: nonzero outside FEED %0d times, required 0", xnz);
    end
  endtask

  task automatic test_back_to_back_random;
    logic [DW-1:0] base = 64'h1111_2222_3333_0000;
    core_lat = 40;
    load_frame(base, 50, WORDS);
    drain_frame(base, 30, 40, 16'd2, "random");
  endtask

  task automatic test_early_strobe;
    logic [DW-1:0] base = 64'hA5A5_0000_0000_0100;
    core_lat = 20;
    load_frame(base, 0, WORDS);
    drain_frame(base, 0, 20, 16'd3, "early");
  endtask

  task automatic test_timeout;
    logic [DW-1:0] base = 64'h5555_0000_0000_0200;
    core_lat = 0;
    load_frame(base, 0, WORDS);
    tests_run++;
    if (core_next_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL tmo_start: core_next=%b, required 1", core_next_o);
    end
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (n == 63) begin
        tests_run++;
        if (err_timeout_o !== 1'b0 || busy_o !== 1'b1) begin
          tests_failed++;
          $display("FAIL tmo_early: at T+63 err=%b busy=%b, required 0 1", err_timeout_o, busy_o);
        end
      end
    end
    tests_run++;
    if (err_timeout_o !== 1'b1 || busy_o !== 1'b0 || in_ready_o !== 1'b1 || frame_cnt_o !== 16'd3) begin
      tests_failed++;
      $display("FAIL tmo_fire: at T+64 err=%b busy=%b rdy=%b cnt=%0d, required 1 0 1 3",
               err_timeout_o, busy_o, in_ready_o, frame_cnt_o);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    tests_run++;
    if (err_timeout_o !== 1'b0 || frame_cnt_o !== 16'd3) begin
      tests_failed++;
      $display("FAIL tmo_abort_clear: err=%b cnt=%0d, required 0 3", err_timeout_o, frame_cnt_o);
    end
  endtask

  task automatic test_abort_load;
    int nh0;
    logic [DW-1:0] base = 64'h0F0F_0000_0000_0300;
    core_lat = 40;
    nh0 = next_high;
    load_frame(64'hBAD0_0000_0000_0000, 0, 10);
    abort_i = 1'b1;
    in_valid_i = 1'b1;
    in_data_i = 64'hBAD1_BAD1_BAD1_BAD1;
    @(negedge clk);
    abort_i = 1'b0;
    in_valid_i = 1'b0;
    tests_run++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: in_ready=%b busy=%b, required 1 0", in_ready_o, busy_o);
    end
    load_frame(base, 0, WORDS);
    drain_frame(base, 0, 40, 16'd4, "abort");
    tests_run++;
    if (next_high - nh0 != 1) begin
      tests_failed++;
      $display("FAIL abort_next_pulse: %0d high cycles, required 1", next_high - nh0);
    end
  endtask

  task automatic test_reset_mid_feed;
    logic [DW-1:0] base = 64'h7777_0000_0000_0400;
    core_lat = 40;
    load_frame(64'h3C3C_0000_0000_0500, 0, WORDS);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (in_ready_o !== 1'b0 || core_x_o !== '0 || busy_o !== 1'b0 || frame_cnt_o !== '0 ||
        out_valid_o !== 1'b0 || core_next_o !== 1'b0 || err_timeout_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: rdy=%b x=%h busy=%b cnt=%0d vld=%b nxt=%b err=%b, required all 0",
               in_ready_o, core_x_o, busy_o, frame_cnt_o, out_valid_o, core_next_o, err_timeout_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    load_frame(base, 0, WORDS);
    drain_frame(base, 0, 40, 16'd1, "post_reset");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_random();
    test_early_strobe();
    test_timeout();
    test_abort_load();
    test_reset_mid_feed();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
